// File: rtl/bus_cycle_terminator.sv
// Merges fast-RAM, 6800-emulation and motherboard /DTACK into one CPU /DTACK,
// with a bus-error watchdog and a sticky timeout flag.
module bus_cycle_terminator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned FAST_WAIT      = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic AS,
  input  logic FAST_SEL,
  input  logic VMA_DTACK,
  input  logic MB_DTACK,
  input  logic TO_CLR,
  output logic DTACK,
  output logic BERR,
  output logic CYCLE_ACTIVE,
  output logic TIMEOUT_FLAG
);

  localparam logic [CNT_WIDTH-1:0] WdLast   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]           WaitInit = 4'(FAST_WAIT);

  typedef enum logic [1:0] {StIdle, StRun, StAck, StBerr} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 fast_q, fast_d;
  logic                 dtack_q, berr_q, active_q;
  logic                 flag_q, flag_d;
  logic                 timeout_set;

  always_comb begin
    state_d     = state_q;
    wd_cnt_d    = wd_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fast_d      = fast_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!AS) begin
          state_d    = StRun;
          wd_cnt_d   = '0;
          wait_cnt_d = WaitInit;
          fast_d     = FAST_SEL;
        end
      end
      StRun: begin
        // Abort first, then acknowledges, so an ack always beats the timeout.
        if (AS) begin
          state_d = StIdle;
        end else if (fast_q && (wait_cnt_q == 4'd0)) begin
          state_d = StAck;
        end else if (!VMA_DTACK) begin
          state_d = StAck;
        end else if (!MB_DTACK) begin
          state_d = StAck;
        end else if (wd_cnt_q == WdLast) begin
          state_d     = StBerr;
          timeout_set = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (fast_q && (wait_cnt_q != 4'd0)) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
      end
      StAck, StBerr: begin
        if (AS) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    flag_d = timeout_set ? 1'b1 : (TO_CLR ? 1'b0 : flag_q);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      wd_cnt_q   <= '0;
      wait_cnt_q <= '0;
      fast_q     <= 1'b0;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      active_q   <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_cnt_q   <= wd_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      fast_q     <= fast_d;
      dtack_q    <= (state_d != StAck);
      berr_q     <= (state_d != StBerr);
      active_q   <= (state_d != StIdle);
      flag_q     <= flag_d;
    end
  end

  // AS gating releases the CPU strobes without waiting for a clock edge.
  assign DTACK        = dtack_q | AS;
  assign BERR         = berr_q | AS;
  assign CYCLE_ACTIVE = active_q;
  assign TIMEOUT_FLAG = flag_q;

endmodule
